// File: rtl/mcu_cmd_initiator.sv
// mcu_cmd_initiator
// Drives the 32-bit command word {command[3:0], data[27:0]} towards the
// command/response responder and samples its response word. Each transaction
// holds the command for HOLD_CYCLES, samples the response on the last hold
// cycle, then drives NO_COMMAND (0) for GAP_CYCLES to re-arm the responder.
//
// Optional feature macro: MCU_CMD_INITIATOR_AUTOPOLL_EN
//   When defined, a free-running counter requests a GET_FQ_INC poll every
//   POLL_PERIOD cycles. Polls complete on poll_valid/poll_delta and never
//   on rsp_valid. A request offered in the same cycle wins over a poll.
//   When undefined, poll_valid and poll_delta are tied to 0.
//
// Ports
//   aclk        in   clock
//   reset       in   synchronous, active-high reset
//   req_valid   in   request offered
//   req_ready   out  request accepted this cycle (combinational from state)
//   req_cmd     in   command nibble (1 = GET_FQ_INC, 2 = SET_PHASE_INC)
//   req_data    in   28-bit command payload
//   cmd_word    out  registered command word to the responder
//   rsp_word    in   responder response word
//   rsp_valid   out  one-cycle pulse, request transaction complete
//   rsp_data    out  sampled rsp_word, held until the next completion
//   busy        out  high whenever not IDLE
//   poll_valid  out  one-cycle pulse, autopoll complete
//   poll_delta  out  rsp_word[7:0] of the last autopoll (signed)
module mcu_cmd_initiator #(
   parameter int unsigned HOLD_CYCLES = 32,
   parameter int unsigned GAP_CYCLES  = 4,
   parameter int unsigned POLL_PERIOD = 100000
) (
   input  logic        aclk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_cmd,
   input  logic [27:0] req_data,
   output logic [31:0] cmd_word,
   input  logic [31:0] rsp_word,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic        poll_valid,
   output logic [7:0]  poll_delta
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [3:0]  CMD_NONE       = 4'h0;
   localparam logic [3:0]  CMD_GET_FQ_INC = 4'h1;

   // Elaboration-time parameter range check
   if (HOLD_CYCLES < 2 || GAP_CYCLES < 1 || POLL_PERIOD < 2) begin : g_bad_params
      $error("mcu_cmd_initiator: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       cmd_word_q, cmd_word_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [31:0]       rsp_data_q, rsp_data_d;

   // Poll interface into the FSM; constant 0 when autopoll is compiled out
   logic              poll_pending_c;
   logic              is_poll_c;

   // State and datapath registers
   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_word_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_word_q  <= cmd_word_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Next-state, counter and command/response datapath
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_word_d  = cmd_word_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      req_ready   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // A pending poll only claims IDLE when no request is offered
            req_ready  = !(poll_pending_c && !req_valid);
            cmd_word_d = '0;
            if (req_valid) begin
               if (req_cmd == CMD_NONE) begin
                  // NO_COMMAND request completes immediately with zero data
                  state_d     = ST_GAP;
                  cnt_d       = CNT_W'(GAP_CYCLES);
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
               end else begin
                  state_d    = ST_ISSUE;
                  cnt_d      = CNT_W'(HOLD_CYCLES);
                  cmd_word_d = {req_cmd, req_data};
               end
            end else if (poll_pending_c) begin
               state_d    = ST_ISSUE;
               cnt_d      = CNT_W'(HOLD_CYCLES);
               cmd_word_d = {CMD_GET_FQ_INC, 28'h0};
            end
         end

         ST_ISSUE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Last hold cycle: responder has settled, capture its answer
               state_d    = ST_GAP;
               cnt_d      = CNT_W'(GAP_CYCLES);
               cmd_word_d = '0;
               if (!is_poll_c) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = rsp_word;
               end
            end
         end

         ST_GAP: begin
            cmd_word_d = '0;
            cnt_d      = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            cmd_word_d = '0;
         end
      endcase
   end

   assign cmd_word  = cmd_word_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != ST_IDLE);

`ifdef MCU_CMD_INITIATOR_AUTOPOLL_EN
   localparam int unsigned POLL_W = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;

   logic [POLL_W-1:0] poll_cnt_q;
   logic              poll_pending_q;
   logic              is_poll_q;
   logic              poll_valid_q;
   logic [7:0]        poll_delta_q;
   logic              poll_wrap_c;
   logic              poll_issue_c;
   logic              poll_done_c;

   assign poll_wrap_c  = (poll_cnt_q == POLL_W'(POLL_PERIOD - 1));
   assign poll_issue_c = (state_q == ST_IDLE) && poll_pending_q && !req_valid;
   assign poll_done_c  = (state_q == ST_ISSUE) && (cnt_q == CNT_W'(1)) && is_poll_q;

   // Poll timer, sticky pending flag and poll completion outputs
   always_ff @(posedge aclk) begin
      if (reset) begin
         poll_cnt_q     <= '0;
         poll_pending_q <= 1'b0;
         is_poll_q      <= 1'b0;
         poll_valid_q   <= 1'b0;
         poll_delta_q   <= '0;
      end else begin
         poll_cnt_q <= poll_wrap_c ? '0 : poll_cnt_q + POLL_W'(1);
         // A fresh expiry outranks the clear from a poll issued that cycle
         if (poll_wrap_c) begin
            poll_pending_q <= 1'b1;
         end else if (poll_issue_c) begin
            poll_pending_q <= 1'b0;
         end
         // Tag the transaction launched from IDLE as poll or request
         if (state_q == ST_IDLE) begin
            is_poll_q <= poll_issue_c;
         end
         poll_valid_q <= poll_done_c;
         if (poll_done_c) begin
            poll_delta_q <= rsp_word[7:0];
         end
      end
   end

   assign poll_pending_c = poll_pending_q;
   assign is_poll_c      = is_poll_q;
   assign poll_valid     = poll_valid_q;
   assign poll_delta     = poll_delta_q;
`else
   assign poll_pending_c = 1'b0;
   assign is_poll_c      = 1'b0;
   assign poll_valid     = 1'b0;
   assign poll_delta     = 8'h00;
`endif

endmodule

// File: tb/tb_mcu_cmd_initiator.sv
// Bench for mcu_cmd_initiator. Expected behaviour is derived from the
// transaction timing rules (accept edge, hold window, gap window) using cycle
// arithmetic and queues; randomized commands, payloads and response words.
module tb_mcu_cmd_initiator;

   localparam int unsigned HOLD   = 32;
   localparam int unsigned GAP    = 4;
   localparam int unsigned PERIOD = 100;
   localparam logic [31:0] POLL_WORD = 32'h1000_0000;

   logic        aclk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_cmd;
   logic [27:0] req_data;
   logic [31:0] cmd_word;
   logic [31:0] rsp_word;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        busy;
   logic        poll_valid;
   logic [7:0]  poll_delta;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] log_q[$];
   bit          mon_en = 1'b0;

   mcu_cmd_initiator #(
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP),
      .POLL_PERIOD (PERIOD)
   ) dut (
      .aclk       (aclk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_cmd    (req_cmd),
      .req_data   (req_data),
      .cmd_word   (cmd_word),
      .rsp_word   (rsp_word),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .busy       (busy),
      .poll_valid (poll_valid),
      .poll_delta (poll_delta)
   );

   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;
   always @(negedge aclk) if (mon_en) log_q.push_back(cmd_word);

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req_valid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Waits (bounded) for an IDLE cycle in which the offered request is taken
   task automatic wait_ready(input string tag, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4 * (HOLD + GAP + 2); i++) begin
         if (req_ready === 1'b1 && busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s_ready_timeout got req_ready=%b busy=%b need ready within budget", tag, req_ready, busy);
      end
   endtask

   // One full transaction checked against the hold/gap timeline
   task automatic run_txn(input string tag, input logic [3:0] c, input logic [27:0] d,
                          input int change_at, input logic [31:0] new_rsp);
      bit          ok;
      logic [31:0] exp_word;
      logic [31:0] exp_rsp;
      logic [34:0] obs35, exp35;
      logic [66:0] obs67, exp67;
      do_reset();
      req_cmd   = c;
      req_data  = d;
      req_valid = 1'b1;
      wait_ready(tag, ok);
      if (!ok) return;
      tick();                                   // accept edge t
      req_valid = 1'b0;
      req_cmd   = 4'($urandom);
      req_data  = 28'($urandom);
      exp_word  = {c, d};
      exp_rsp   = 32'h0;
      if (c != 4'h0) begin
         for (int k = 1; k <= int'(HOLD); k++) begin
            if (k == change_at) rsp_word = new_rsp;
            obs35 = {cmd_word, rsp_valid, req_ready, busy};
            exp35 = {exp_word, 1'b0, 1'b0, 1'b1};
            total++;
            if (obs35 !== exp35) begin
               bad++;
               $display("FAIL %s_hold k=%0d got word=%h v/rdy/busy=%b need word=%h v/rdy/busy=%b",
                        tag, k, obs35[34:3], obs35[2:0], exp35[34:3], exp35[2:0]);
            end
            if (k == int'(HOLD)) exp_rsp = rsp_word;
            tick();
         end
      end
      for (int g = 1; g <= int'(GAP); g++) begin
         obs67 = {cmd_word, rsp_valid, req_ready, busy, rsp_data};
         exp67 = {32'h0, (g == 1), 1'b0, 1'b1, exp_rsp};
         total++;
         if (obs67 !== exp67) begin
            bad++;
            $display("FAIL %s_gap g=%0d got word=%h v/rdy/busy=%b data=%h need word=%h v/rdy/busy=%b data=%h",
                     tag, g, obs67[66:35], obs67[34:32], obs67[31:0], exp67[66:35], exp67[34:32], exp67[31:0]);
         end
         tick();
      end
      obs67 = {cmd_word, rsp_valid, req_ready, busy, rsp_data};
      exp67 = {32'h0, 1'b0, 1'b1, 1'b0, exp_rsp};
      total++;
      if (obs67 !== exp67) begin
         bad++;
         $display("FAIL %s_rearm got word=%h v/rdy/busy=%b data=%h need word=%h v/rdy/busy=%b data=%h",
                  tag, obs67[66:35], obs67[34:32], obs67[31:0], exp67[66:35], exp67[34:32], exp67[31:0]);
      end
   endtask

   task automatic test_reset();
      logic [45:0] obs;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'($urandom);
         req_cmd   = 4'($urandom);
         req_data  = 28'($urandom);
         rsp_word  = $urandom;
         tick();
         obs = {cmd_word, rsp_valid, busy, poll_valid, poll_delta, req_ready, rsp_data == 32'h0};
         total++;
         if (obs !== {32'h0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL reset_values cyc=%0d got %h need %h", i, obs, {32'h0, 13'b0_0_0_00000000_1_1});
         end
      end
      req_valid = 1'b0;
      reset = 1'b0;
      tick();
      total++;
      if ({req_ready, busy, cmd_word, rsp_data} !== {1'b1, 1'b0, 32'h0, 32'h0}) begin
         bad++;
         $display("FAIL reset_release got rdy=%b busy=%b word=%h data=%h need rdy=1 busy=0 word=0 data=0",
                  req_ready, busy, cmd_word, rsp_data);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      req_cmd   = 4'h2;
      req_data  = 28'($urandom);
      req_valid = 1'b1;
      wait_ready("midrst", ok);
      if (!ok) return;
      tick();                                   // accept edge t
      req_valid = 1'b0;
      repeat (4) tick();                        // cycle t+5
      reset = 1'b1;
      tick();
      total++;
      if ({cmd_word, rsp_valid, busy, rsp_data} !== {32'h0, 1'b0, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL midrst_after_edge got word=%h v=%b busy=%b data=%h need all 0",
                  cmd_word, rsp_valid, busy, rsp_data);
      end
      reset = 1'b0;
      for (int i = 0; i < int'(HOLD + GAP + 6); i++) begin
         total++;
         if ({rsp_valid, cmd_word, busy, req_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL midrst_quiet i=%0d got v=%b word=%h busy=%b rdy=%b need v=0 word=0 busy=0 rdy=1",
                     i, rsp_valid, cmd_word, busy, req_ready);
            break;
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      localparam int N = 6;
      logic [31:0] sent[$];
      int          acc[$];
      logic [31:0] run_word[$];
      int          run_len[$];
      int          gap_len[$];
      logic [31:0] cur;
      int          len, zeros;
      bit          ok;
      do_reset();
      log_q.delete();
      req_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
         req_cmd  = 4'($urandom_range(1, 15));
         req_data = 28'($urandom);
         sent.push_back({req_cmd, req_data});
         wait_ready("b2b", ok);
         if (!ok) begin
            req_valid = 1'b0;
            return;
         end
         acc.push_back(cyc);
         tick();
         if (i == 0) mon_en = 1'b1;
      end
      req_valid = 1'b0;
      repeat (HOLD + GAP) @(negedge aclk);
      #1;
      mon_en = 1'b0;
      // Split the logged command stream into nonzero runs and zero gaps
      cur = 32'h0; len = 0; zeros = 0;
      foreach (log_q[i]) begin
         if (log_q[i] == 32'h0) begin
            if (len > 0) begin
               run_word.push_back(cur);
               run_len.push_back(len);
               len = 0;
            end
            zeros++;
         end else begin
            if (len > 0 && log_q[i] != cur) begin
               run_word.push_back(cur);
               run_len.push_back(len);
               gap_len.push_back(0);
               len = 0;
            end
            if (len == 0 && run_word.size() > 0 && zeros > 0) gap_len.push_back(zeros);
            cur = log_q[i];
            len++;
            zeros = 0;
         end
      end
      if (len > 0) begin
         run_word.push_back(cur);
         run_len.push_back(len);
      end
      total++;
      if (run_word.size() != N) begin
         bad++;
         $display("FAIL b2b_count got %0d commands need %0d", run_word.size(), N);
         return;
      end
      for (int i = 0; i < N; i++) begin
         total++;
         if (run_word[i] !== sent[i] || run_len[i] != int'(HOLD)) begin
            bad++;
            $display("FAIL b2b_cmd i=%0d got %h x%0d need %h x%0d", i, run_word[i], run_len[i], sent[i], HOLD);
         end
      end
      for (int i = 0; i < gap_len.size(); i++) begin
         total++;
         if (gap_len[i] < int'(GAP)) begin
            bad++;
            $display("FAIL b2b_gap i=%0d got %0d zero cycles need >=%0d", i, gap_len[i], GAP);
         end
      end
      for (int i = 1; i < N; i++) begin
         total++;
         if (acc[i] - acc[i-1] != int'(HOLD + GAP + 1)) begin
            bad++;
            $display("FAIL b2b_period i=%0d got %0d need %0d", i, acc[i] - acc[i-1], HOLD + GAP + 1);
         end
      end
   endtask

`ifdef MCU_CMD_INITIATOR_AUTOPOLL_EN
   task automatic test_autopoll();
      int pulses[$];
      do_reset();
      rsp_word = {24'($urandom), 8'h03};
      for (int i = 0; i < 450; i++) begin
         if (poll_valid === 1'b1) begin
            pulses.push_back(i);
            total++;
            if (poll_delta !== 8'h03) begin
               bad++;
               $display("FAIL poll_delta i=%0d got %h need 03", i, poll_delta);
            end
         end
         if (rsp_valid !== 1'b0 || (cmd_word !== 32'h0 && cmd_word !== POLL_WORD)) begin
            total++;
            bad++;
            $display("FAIL poll_side i=%0d got rsp_valid=%b word=%h need 0 and poll word", i, rsp_valid, cmd_word);
         end
         tick();
      end
      total++;
      if (pulses.size() != 4) begin
         bad++;
         $display("FAIL poll_count got %0d need 4", pulses.size());
      end
      for (int i = 1; i < pulses.size(); i++) begin
         total++;
         if (pulses[i] - pulses[i-1] != int'(PERIOD)) begin
            bad++;
            $display("FAIL poll_spacing i=%0d got %0d need %0d", i, pulses[i] - pulses[i-1], PERIOD);
         end
      end
   endtask

   task automatic test_poll_priority();
      bit          found;
      logic [31:0] exp_word;
      int          nrsp, npoll, bad_hold;
      do_reset();
      rsp_word = $urandom;
      found = 1'b0;
      // A pending poll shows as req_ready low while idle with no request
      for (int i = 0; i < int'(3 * PERIOD); i++) begin
         if (busy === 1'b0 && req_ready === 1'b0) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL prio_pending_timeout got no pending poll need one within %0d cycles", 3 * PERIOD);
         return;
      end
      req_cmd   = 4'h2;
      req_data  = 28'($urandom);
      exp_word  = {req_cmd, req_data};
      req_valid = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL prio_ready got %b need 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      nrsp = 0; npoll = 0; bad_hold = 0;
      for (int k = 1; k <= int'(2 * (HOLD + GAP) + 20); k++) begin
         if (k <= int'(HOLD) && cmd_word !== exp_word) bad_hold++;
         if (k == int'(HOLD + GAP + 1)) begin
            total++;
            if ({req_ready, busy} !== 2'b00) begin
               bad++;
               $display("FAIL prio_idle_poll got rdy=%b busy=%b need rdy=0 busy=0", req_ready, busy);
            end
         end
         if (k == int'(HOLD + GAP + 2)) begin
            total++;
            if (cmd_word !== POLL_WORD) begin
               bad++;
               $display("FAIL prio_poll_word got %h need %h", cmd_word, POLL_WORD);
            end
         end
         if (rsp_valid === 1'b1) nrsp++;
         if (poll_valid === 1'b1) npoll++;
         tick();
      end
      total++;
      if (bad_hold != 0 || nrsp != 1 || npoll != 1) begin
         bad++;
         $display("FAIL prio_counts got hold_err=%0d rsp=%0d poll=%0d need 0/1/1", bad_hold, nrsp, npoll);
      end
   endtask
`else
   task automatic test_no_poll();
      do_reset();
      rsp_word = $urandom;
      for (int i = 0; i < int'(2 * PERIOD + 50); i++) begin
         total++;
         if ({poll_valid, poll_delta, cmd_word, busy} !== {1'b0, 8'h00, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL no_poll i=%0d got pv=%b pd=%h word=%h busy=%b need all 0",
                     i, poll_valid, poll_delta, cmd_word, busy);
            break;
         end
         tick();
      end
   endtask
`endif

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_cmd   = 4'h0;
      req_data  = 28'h0;
      rsp_word  = 32'h0;

      test_reset();

      rsp_word = $urandom;
      run_txn("set_phase", 4'h2, 28'h0800000, 0, 32'h0);

      rsp_word = 32'h1234_5678;
      run_txn("get_fq", 4'h1, 28'($urandom), 10, 32'hFFFF_FFFD);

      rsp_word = $urandom;
      run_txn("no_cmd", 4'h0, 28'($urandom), 0, 32'h0);

      rsp_word = $urandom;
      run_txn("unknown_cmd", 4'hB, 28'($urandom), 0, 32'h0);

      for (int i = 0; i < 4; i++) begin
         rsp_word = $urandom;
         run_txn("random", 4'($urandom), 28'($urandom), int'($urandom_range(1, HOLD)), $urandom);
      end

      test_back_to_back();
      test_reset_mid();

`ifdef MCU_CMD_INITIATOR_AUTOPOLL_EN
      test_autopoll();
      test_poll_priority();
`else
      test_no_poll();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
